// File: rtl/freq_report_scheduler.sv
// freq_report_scheduler
//   Periodic report sequencer between NUM_CH freq_meter channels and a UART
//   sender. Each report period it snapshots every channel result, then issues
//   one send_en per eligible channel in index order, with a start/busy
//   handshake to the sender. Ticks that land on a busy frame are counted in
//   missed_cnt. Handshakes the sender never acknowledges are counted in err_cnt.
//
// Optional feature: define REPORT_ONCHANGE_EN to skip channels whose snapshot
//   matches the value last sent for that channel.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   enable      0 holds the period counter at 0 so no new frames start
//   period_cfg  report period in cycles, 0 selects PERIOD_CYCLES
//   ch_freq     packed channel frequencies, ch0 in the LSBs
//   ch_duty     packed channel duties, ch0 in the LSBs
//   ch_valid    per-channel result valid
//   tx_busy     sender busy
//   send_en     one-cycle start pulse to the sender
//   rep_ch      index of the reported channel
//   rep_freq    reported frequency
//   rep_duty    reported duty
//   frame_busy  frame in progress, including the tick cycle
//   missed_cnt  saturating count of ticks lost to a busy frame
//   err_cnt     saturating count of acknowledge timeouts
module freq_report_scheduler #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned FREQ_W        = 34,
  parameter int unsigned DUTY_W        = 8,
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned PERIOD_CYCLES = 50_000_000,
  parameter int unsigned ACK_TIMEOUT   = 1024,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [CNT_W-1:0]         period_cfg,
  input  logic [NUM_CH*FREQ_W-1:0] ch_freq,
  input  logic [NUM_CH*DUTY_W-1:0] ch_duty,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic                     tx_busy,
  output logic                     send_en,
  output logic [CH_W-1:0]          rep_ch,
  output logic [FREQ_W-1:0]        rep_freq,
  output logic [DUTY_W-1:0]        rep_duty,
  output logic                     frame_busy,
  output logic [15:0]              missed_cnt,
  output logic [7:0]               err_cnt
);

  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StScan, StStart, StWaitAck, StWaitDone, StNext} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CH_W-1:0]       idx_q, idx_d;
  logic [FREQ_W-1:0]     snap_freq_q [NUM_CH];
  logic [FREQ_W-1:0]     snap_freq_d [NUM_CH];
  logic [DUTY_W-1:0]     snap_duty_q [NUM_CH];
  logic [DUTY_W-1:0]     snap_duty_d [NUM_CH];
  logic [NUM_CH-1:0]     snap_valid_q, snap_valid_d;
  logic [CH_W-1:0]       rep_ch_q, rep_ch_d;
  logic [FREQ_W-1:0]     rep_freq_q, rep_freq_d;
  logic [DUTY_W-1:0]     rep_duty_q, rep_duty_d;
  logic [15:0]           missed_q, missed_d;
  logic [7:0]            err_q, err_d;
  logic [AckW-1:0]       ack_q, ack_d;
  logic [CNT_W-1:0]      period;
  logic                  tick;
  logic                  last_ch;
  logic                  changed;

`ifdef REPORT_ONCHANGE_EN
  logic [FREQ_W+DUTY_W-1:0] sent_q [NUM_CH];
  logic [FREQ_W+DUTY_W-1:0] sent_d [NUM_CH];

  always_comb begin
    sent_d  = sent_q;
    changed = ({snap_freq_q[idx_q], snap_duty_q[idx_q]} != sent_q[idx_q]);
    if (send_en) sent_d[rep_ch_q] = {rep_freq_q, rep_duty_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) sent_q[i] <= '0;
    end else begin
      sent_q <= sent_d;
    end
  end
`else
  assign changed = 1'b1;
`endif

  always_comb begin
    period  = (period_cfg == '0) ? CNT_W'(PERIOD_CYCLES) : period_cfg;
    // >= so that lowering the period below the current count fires at once.
    // Gated by rst so no output can rise while reset is held.
    tick    = enable & ~rst & (cnt_q >= period - CNT_W'(1));
    last_ch = (idx_q == CH_W'(NUM_CH - 1));

    cnt_d   = (!enable || tick) ? '0 : cnt_q + CNT_W'(1);

    state_d      = state_q;
    idx_d        = idx_q;
    snap_freq_d  = snap_freq_q;
    snap_duty_d  = snap_duty_q;
    snap_valid_d = snap_valid_q;
    rep_ch_d     = rep_ch_q;
    rep_freq_d   = rep_freq_q;
    rep_duty_d   = rep_duty_q;
    missed_d     = missed_q;
    err_d        = err_q;
    ack_d        = ack_q;
    send_en      = 1'b0;

    unique case (state_q)
      StScan: begin
        if (snap_valid_q[idx_q] && changed) begin
          rep_ch_d   = idx_q;
          rep_freq_d = snap_freq_q[idx_q];
          rep_duty_d = snap_duty_q[idx_q];
          state_d    = StStart;
        end else if (last_ch) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + CH_W'(1);
        end
      end
      StStart: begin
        if (!tx_busy) begin
          send_en = 1'b1;
          ack_d   = '0;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (ack_q == AckW'(ACK_TIMEOUT - 1)) begin
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          state_d = StNext;
        end else begin
          ack_d = ack_q + AckW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy) state_d = StNext;
      end
      StNext: begin
        if (last_ch) begin
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + CH_W'(1);
          state_d = StScan;
        end
      end
      default: ;
    endcase

    if (tick) begin
      if (state_q == StIdle) begin
        for (int i = 0; i < NUM_CH; i++) begin
          snap_freq_d[i] = ch_freq[i*FREQ_W +: FREQ_W];
          snap_duty_d[i] = ch_duty[i*DUTY_W +: DUTY_W];
        end
        snap_valid_d = ch_valid;
        idx_d        = '0;
        state_d      = StScan;
      end else begin
        missed_d = (missed_q == 16'hFFFF) ? missed_q : missed_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_valid_q <= '0;
      rep_ch_q     <= '0;
      rep_freq_q   <= '0;
      rep_duty_q   <= '0;
      missed_q     <= '0;
      err_q        <= '0;
      ack_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_freq_q[i] <= '0;
        snap_duty_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_valid_q <= snap_valid_d;
      rep_ch_q     <= rep_ch_d;
      rep_freq_q   <= rep_freq_d;
      rep_duty_q   <= rep_duty_d;
      missed_q     <= missed_d;
      err_q        <= err_d;
      ack_q        <= ack_d;
      snap_freq_q  <= snap_freq_d;
      snap_duty_q  <= snap_duty_d;
    end
  end

  assign frame_busy = (state_q != StIdle) | tick;
  assign rep_ch     = rep_ch_q;
  assign rep_freq   = rep_freq_q;
  assign rep_duty   = rep_duty_q;
  assign missed_cnt = missed_q;
  assign err_cnt    = err_q;

endmodule
